// File: rtl/bnn_cfg_sequencer.sv
// Sequencer for a small binary neural net: loads per-neuron weight/threshold
// from a nibble stream into the datapath store, then runs one-shot inferences.
module bnn_cfg_sequencer #(
   parameter int NUM_NEURONS = 8,
   parameter int EVAL_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_start,
   input  logic       cfg_abort,
   input  logic       nib_valid,
   input  logic [3:0] nib_data,
   output logic       nib_ready,
   output logic       cfg_we,
   output logic [2:0] cfg_addr,
   output logic [7:0] cfg_weight,
   output logic [3:0] cfg_thresh,
   output logic       cfg_done,
   output logic       cfg_err,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic [7:0] dp_data,
   input  logic [3:0] dp_result,
   output logic       res_valid,
   output logic [3:0] res_data,
   input  logic       res_ready,
   output logic       busy
);

   localparam logic [2:0] LAST_IDX  = 3'(NUM_NEURONS - 1);
   localparam logic [3:0] EVAL_INIT = 4'(EVAL_CYCLES);

   typedef enum logic [2:0] {
      IDLE, LD_WLO, LD_WHI, LD_TH, COMMIT, EVAL, RESULT
   } state_t;

   state_t     state, state_n;
   logic [2:0] index;
   logic [3:0] cnt;
   logic [3:0] w_lo, w_hi;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      nib_ready = 1'b0;
      in_ready  = 1'b0;
      cfg_we    = 1'b0;
      cfg_done  = 1'b0;
      cfg_err   = 1'b0;
      res_valid = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_start) state_n = LD_WLO;
            else begin
               in_ready = ~reset;
               if (in_valid) state_n = EVAL;
            end
         end
         LD_WLO, LD_WHI, LD_TH: begin
            nib_ready = 1'b1;
            if (cfg_abort) begin
               cfg_err = 1'b1;
               state_n = IDLE;
            end else if (nib_valid) begin
               case (state)
                  LD_WLO:  state_n = LD_WHI;
                  LD_WHI:  state_n = LD_TH;
                  default: state_n = COMMIT;
               endcase
            end
         end
         COMMIT: begin
            cfg_we = 1'b1;
            if (index == LAST_IDX) begin
               cfg_done = 1'b1;
               state_n  = IDLE;
            end else state_n = LD_WLO;
         end
         EVAL: if (cnt <= 4'd1) state_n = RESULT;
         RESULT: begin
            res_valid = 1'b1;
            if (res_ready) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // cfg_* data registers change only when a complete neuron is assembled,
   // so an aborted partial neuron never reaches the outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         index      <= '0;
         cnt        <= '0;
         w_lo       <= '0;
         w_hi       <= '0;
         cfg_addr   <= '0;
         cfg_weight <= '0;
         cfg_thresh <= '0;
         dp_data    <= '0;
         res_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               index <= '0;
               if (!cfg_start && in_valid) begin
                  dp_data <= in_data;
                  cnt     <= EVAL_INIT;
               end
            end
            LD_WLO: begin
               if (cfg_abort) index <= '0;
               else if (nib_valid) w_lo <= nib_data;
            end
            LD_WHI: begin
               if (cfg_abort) index <= '0;
               else if (nib_valid) w_hi <= nib_data;
            end
            LD_TH: begin
               if (cfg_abort) index <= '0;
               else if (nib_valid) begin
                  cfg_addr   <= index;
                  cfg_weight <= {w_hi, w_lo};
                  cfg_thresh <= nib_data;
               end
            end
            COMMIT: index <= (index == LAST_IDX) ? 3'd0 : index + 3'd1;
            EVAL: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd1) res_data <= dp_result;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_bnn_cfg_sequencer.sv
// Directed bench for bnn_cfg_sequencer: config load, abort, inference, reset.
module tb_bnn_cfg_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_start, cfg_abort, nib_valid;
   logic [3:0] nib_data;
   logic       nib_ready, cfg_we, cfg_done, cfg_err;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_weight;
   logic [3:0] cfg_thresh;
   logic       in_valid, in_ready;
   logic [7:0] in_data, dp_data;
   logic [3:0] dp_result, res_data;
   logic       res_valid, res_ready, busy;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0, done_cnt = 0, err_cnt = 0;
   logic [14:0] wq[$];

   bnn_cfg_sequencer dut (
      .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
      .nib_valid(nib_valid), .nib_data(nib_data), .nib_ready(nib_ready),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_weight(cfg_weight),
      .cfg_thresh(cfg_thresh), .cfg_done(cfg_done), .cfg_err(cfg_err),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .dp_data(dp_data), .dp_result(dp_result), .res_valid(res_valid),
      .res_data(res_data), .res_ready(res_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   // Write-strobe log sampled mid-cycle
   always @(negedge clk) begin
      if (!reset) begin
         if (cfg_we) begin
            we_cnt++;
            wq.push_back({cfg_addr, cfg_weight, cfg_thresh});
         end
         if (cfg_done) done_cnt++;
         if (cfg_err)  err_cnt++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [3:0] d, input bit gappy);
      int n = 0;
      bit acc = 1'b0;
      while (!acc && n < 50) begin
         nib_valid = gappy ? 1'($urandom_range(0, 1)) : 1'b1;
         nib_data  = d;
         #1;
         acc = nib_valid && nib_ready;
         tick();
         n++;
      end
      nib_valid = 1'b0;
      if (!acc) chk("feed_timeout", 32'(acc), 32'd1);
   endtask

   int base_we, base_done, base_err, base_q;

   initial begin
      reset = 1'b1; cfg_start = 0; cfg_abort = 0; nib_valid = 0; nib_data = 0;
      in_valid = 0; in_data = 0; dp_result = 0; res_ready = 0;
      #3;
      chk("rst_nib_ready", nib_ready, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_cfg_we", cfg_we, 0);
      chk("rst_cfg_regs", {cfg_addr, cfg_weight, cfg_thresh}, 0);
      chk("rst_pulses", {cfg_done, cfg_err}, 0);
      chk("rst_dp", {dp_data, res_valid, res_data, busy}, 0);
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1);

      // Single neuron 0,F,5 then one nibble more and abort (4 accepted)
      base_we = we_cnt; base_err = err_cnt; base_q = wq.size();
      cfg_start = 1; #1;
      chk("start_in_ready", in_ready, 0);
      tick(); cfg_start = 0; #1;
      chk("ld_nib_ready", nib_ready, 1);
      chk("ld_busy", busy, 1);
      feed(4'h0, 0); feed(4'hF, 0); feed(4'h5, 0);
      chk("commit_we", cfg_we, 1);
      chk("commit_data", {cfg_addr, cfg_weight, cfg_thresh}, {3'd0, 8'hF0, 4'h5});
      chk("commit_done", cfg_done, 0);
      tick();
      chk("post_commit_we", cfg_we, 0);
      chk("hold_weight", cfg_weight, 8'hF0);
      feed(4'h4, 0);
      cfg_abort = 1; nib_valid = 1; nib_data = 4'h9; #1;
      chk("abort_err", cfg_err, 1);
      tick(); cfg_abort = 0; nib_valid = 0; #1;
      chk("abort_idle", busy, 0);
      chk("abort_err_clr", cfg_err, 0);
      chk("abort_we_count", we_cnt - base_we, 1);
      chk("abort_err_count", err_cnt - base_err, 1);
      chk("abort_regs", {cfg_addr, cfg_weight, cfg_thresh}, {3'd0, 8'hF0, 4'h5});

      // Full load with random nibble gaps
      base_we = we_cnt; base_done = done_cnt; base_q = wq.size();
      cfg_start = 1; tick(); cfg_start = 0;
      for (int i = 0; i < 8; i++) begin
         feed(4'(i), 1); feed(4'(i + 8), 1);
         if (i == 7) begin
            feed(4'(15 - i), 1);
            chk("last_we", cfg_we, 1);
            chk("last_done", cfg_done, 1);
            chk("last_addr", cfg_addr, 7);
         end else feed(4'(15 - i), 1);
      end
      tick();
      chk("full_busy", busy, 0);
      chk("full_we_count", we_cnt - base_we, 8);
      chk("full_done_count", done_cnt - base_done, 1);
      for (int i = 0; i < 8; i++)
         if (base_q + i < wq.size())
            chk($sformatf("full_wr%0d", i), wq[base_q + i],
                {3'(i), 4'(i + 8), 4'(i), 4'(15 - i)});

      // Inference, result held under backpressure
      in_valid = 1; in_data = 8'hA5; dp_result = 4'b1010; #1;
      chk("inf_in_ready", in_ready, 1);
      tick(); in_valid = 0; #1;
      chk("eval_busy", busy, 1);
      chk("eval_res_valid", res_valid, 0);
      chk("eval_dp_data", dp_data, 8'hA5);
      tick();
      dp_result = 4'h3; in_valid = 1; in_data = 8'h11;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("res_valid", res_valid, 1);
         chk("res_data", res_data, 4'hA);
         chk("res_no_accept", in_ready, 0);
         tick();
      end
      in_valid = 0; res_ready = 1;
      tick(); res_ready = 0; #1;
      chk("res_released", {res_valid, busy}, 0);
      chk("dp_hold", dp_data, 8'hA5);

      // Start and input together: load first, input afterwards
      base_we = we_cnt;
      cfg_start = 1; in_valid = 1; in_data = 8'h3C; dp_result = 4'h5; #1;
      chk("prio_in_ready", in_ready, 0);
      tick(); cfg_start = 0; #1;
      chk("prio_in_ready_ld", in_ready, 0);
      for (int i = 0; i < 24; i++) feed(4'(i), 0);
      tick(); #1;
      chk("prio_we_count", we_cnt - base_we, 8);
      chk("prio_in_ready_idle", in_ready, 1);
      tick(); in_valid = 0; #1;
      chk("prio_dp_data", dp_data, 8'h3C);
      tick(); #1;
      chk("prio_res", {res_valid, res_data}, {1'b1, 4'h5});
      res_ready = 1; tick(); res_ready = 0;

      // Reset during EVAL
      base_we = we_cnt;
      in_valid = 1; in_data = 8'h77; tick(); in_valid = 0; #1;
      chk("pre_rst_busy", busy, 1);
      reset = 1; #1;
      chk("mid_rst_outs", {dp_data, res_valid, res_data, busy, in_ready}, 0);
      chk("mid_rst_cfg", {cfg_addr, cfg_weight, cfg_thresh}, 0);
      tick(); reset = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_res_valid", res_valid, 0);
      end
      chk("post_rst_we", we_cnt - base_we, 0);
      chk("post_rst_state", {busy, dp_data, res_data}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
